// File: rtl/focus_metric_pkg.sv
// Shared constants, FSM state type and luma helpers for the focus-metric block.
package focus_pkg;

  localparam int unsigned DEF_H_RES  = 320;
  localparam int unsigned DEF_V_RES  = 240;
  localparam int unsigned DEF_ROI_X0 = 80;
  localparam int unsigned DEF_ROI_Y0 = 60;
  localparam int unsigned DEF_ROI_W  = 160;
  localparam int unsigned DEF_ROI_H  = 120;

  localparam int unsigned LUMA_W    = 7;
  localparam int unsigned ACC_W     = 26;
  localparam int unsigned PIX_CNT_W = 17;
  localparam int unsigned X_W       = 9;
  localparam int unsigned Y_W       = 8;
  localparam int unsigned PIX_W     = 12;
  localparam int unsigned ADDR_W    = 17;

  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } focus_state_e;

  // Y = 2R + 5G + B; 0xFFF gives 120, so 7 bits never overflow.
  function automatic logic [LUMA_W-1:0] luma(input logic [PIX_W-1:0] rgb);
    logic [LUMA_W-1:0] r2, g, b;
    r2 = {2'b00, rgb[11:8], 1'b0};
    g  = {3'b000, rgb[7:4]};
    b  = {3'b000, rgb[3:0]};
    return r2 + (g << 2) + g + b;
  endfunction

  function automatic logic [LUMA_W-1:0] abs_diff(input logic [LUMA_W-1:0] a,
                                                 input logic [LUMA_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/focus_metric_if.sv
// Pixel write stream in, per-frame focus report out.
interface focus_metric_if;
  import focus_pkg::*;

  logic              v_sync;
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic [PIX_W-1:0]  wData;
  logic [ACC_W-1:0]  focus_value;
  logic              focus_valid;
  logic              frame_err;

  modport master (
    output v_sync, we, wAddr, wData,
    input  focus_value, focus_valid, frame_err
  );

  modport slave (
    input  v_sync, we, wAddr, wData,
    output focus_value, focus_valid, frame_err
  );

endinterface

// File: rtl/focus_metric_line_buffer.sv
// One-line luma store: synchronous 1-cycle read, read-before-write on a shared address.
module focus_line_buffer import focus_pkg::*; #(
  parameter int unsigned DEPTH = DEF_H_RES,
  parameter int unsigned WIDTH = LUMA_W,
  parameter int unsigned AW    = X_W
) (
  input  logic             clk_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    rd_data_q <= mem_q[rd_addr_i];
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/focus_metric.sv
// Per-frame sum of absolute horizontal and vertical luma gradients inside a fixed ROI.
module focus_metric import focus_pkg::*; #(
  parameter int unsigned H_RES  = DEF_H_RES,
  parameter int unsigned V_RES  = DEF_V_RES,
  parameter int unsigned ROI_X0 = DEF_ROI_X0,
  parameter int unsigned ROI_Y0 = DEF_ROI_Y0,
  parameter int unsigned ROI_W  = DEF_ROI_W,
  parameter int unsigned ROI_H  = DEF_ROI_H
) (
  input logic           pclk,
  input logic           reset,
  focus_metric_if.slave bus
);

  localparam logic [X_W-1:0]       X_LAST    = X_W'(H_RES - 1);
  localparam logic [X_W-1:0]       X_LO      = X_W'(ROI_X0);
  localparam logic [X_W-1:0]       X_HI      = X_W'(ROI_X0 + ROI_W);
  localparam logic [Y_W-1:0]       Y_MAX     = Y_W'(V_RES);
  localparam logic [Y_W-1:0]       Y_LO      = Y_W'(ROI_Y0);
  localparam logic [Y_W-1:0]       Y_HI      = Y_W'(ROI_Y0 + ROI_H);
  localparam logic [PIX_CNT_W-1:0] FRAME_PIX = PIX_CNT_W'(H_RES * V_RES);

  focus_state_e         state_q, state_d;
  logic                 vs_q;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic                 v1_q, h_en_q, v_en_q;
  logic [LUMA_W-1:0]    ylum_q, yleft_q;
  logic [X_W-1:0]       x1_q;
  logic [LUMA_W-1:0]    y_up;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic                 row_err_q, row_err_d;
  logic [ACC_W-1:0]     focus_value_q, focus_value_d;
  logic                 focus_valid_q, focus_valid_d;
  logic                 frame_err_q, frame_err_d;

  logic                 pix_vld, rise, in_roi;
  logic [LUMA_W-1:0]    luma_now, h_term, v_term;
  logic [ACC_W-1:0]     grad;

  assign pix_vld  = bus.we & ~bus.v_sync;
  assign rise     = bus.v_sync & ~vs_q;
  assign luma_now = luma(bus.wData);
  assign in_roi   = (x_q >= X_LO) && (x_q < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (bus.v_sync) begin
      x_d = '0;
      y_d = '0;
    end else if (bus.we) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q != Y_MAX) y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  focus_line_buffer #(
    .DEPTH (H_RES),
    .WIDTH (LUMA_W),
    .AW    (X_W)
  ) u_line_buf (
    .clk_i     (pclk),
    .rd_addr_i (x_q),
    .rd_data_o (y_up),
    .wr_en_i   (v1_q),
    .wr_addr_i (x1_q),
    .wr_data_i (ylum_q)
  );

  assign h_term = h_en_q ? abs_diff(ylum_q, yleft_q) : '0;
  assign v_term = v_en_q ? abs_diff(ylum_q, y_up) : '0;
  assign grad   = ACC_W'(h_term) + ACC_W'(v_term);

  // A frame-boundary clear wins over any gradient still in flight.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    pix_cnt_d     = pix_cnt_q;
    row_err_d     = row_err_q;
    focus_valid_d = 1'b0;
    focus_value_d = focus_value_q;
    frame_err_d   = frame_err_q;
    case (state_q)
      WAIT_SYNC: begin
        if (rise) begin
          state_d   = RUN;
          acc_d     = '0;
          pix_cnt_d = '0;
          row_err_d = 1'b0;
        end
      end
      RUN: begin
        if (rise) begin
          focus_value_d = acc_q;
          frame_err_d   = (pix_cnt_q != FRAME_PIX) || row_err_q;
          focus_valid_d = 1'b1;
          acc_d         = '0;
          pix_cnt_d     = '0;
          row_err_d     = 1'b0;
        end else begin
          if (v1_q) acc_d = acc_q + grad;
          if (pix_vld) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
            if (y_q == Y_MAX) row_err_d = 1'b1;
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q       <= WAIT_SYNC;
      vs_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      v1_q          <= 1'b0;
      h_en_q        <= 1'b0;
      v_en_q        <= 1'b0;
      ylum_q        <= '0;
      yleft_q       <= '0;
      x1_q          <= '0;
      acc_q         <= '0;
      pix_cnt_q     <= '0;
      row_err_q     <= 1'b0;
      focus_value_q <= '0;
      focus_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= bus.v_sync;
      x_q           <= x_d;
      y_q           <= y_d;
      v1_q          <= pix_vld;
      if (pix_vld) begin
        ylum_q  <= luma_now;
        yleft_q <= ylum_q;
        x1_q    <= x_q;
        h_en_q  <= in_roi && (x_q > X_LO);
        v_en_q  <= in_roi && (y_q > Y_LO);
      end
      acc_q         <= acc_d;
      pix_cnt_q     <= pix_cnt_d;
      row_err_q     <= row_err_d;
      focus_value_q <= focus_value_d;
      focus_valid_q <= focus_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign bus.focus_value = focus_value_q;
  assign bus.focus_valid = focus_valid_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_focus_metric.sv
// Directed-frame bench for focus_metric on a scaled 32x24 geometry with a 16x12 ROI at (8,6).
module tb_focus_metric;
  import focus_pkg::*;

  localparam int unsigned H  = 32;
  localparam int unsigned V  = 24;
  localparam int unsigned X0 = 8;
  localparam int unsigned Y0 = 6;
  localparam int unsigned RW = 16;
  localparam int unsigned RH = 12;

  localparam int K_UNIFORM = 0;
  localparam int K_VSTRIPE = 1;
  localparam int K_HSTRIPE = 2;
  localparam int K_DOT_IN  = 3;
  localparam int K_DOT_OUT = 4;

  logic pclk = 1'b0;
  logic reset;
  always #5 pclk = ~pclk;

  focus_metric_if bus ();

  focus_metric #(
    .H_RES  (H),
    .V_RES  (V),
    .ROI_X0 (X0),
    .ROI_Y0 (Y0),
    .ROI_W  (RW),
    .ROI_H  (RH)
  ) dut (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus)
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          n_valid      = 0;
  logic [31:0] last_val     = '0;
  logic [31:0] last_err     = '0;

  task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (bus.focus_valid === 1'b1) begin
      n_valid++;
      last_val = 32'(bus.focus_value);
      last_err = 32'(bus.frame_err);
    end
  end

  function automatic logic [11:0] pix(input int kind, input int r, input int c);
    logic [11:0] p;
    p = 12'h000;
    if (kind == K_UNIFORM)                    p = 12'h777;
    else if (kind == K_VSTRIPE && c % 2 == 0) p = 12'hFFF;
    else if (kind == K_HSTRIPE && r % 2 == 0) p = 12'hFFF;
    else if (kind == K_DOT_IN && r == 10 && c == 10) p = 12'hFFF;
    else if (kind == K_DOT_OUT && r == 2 && c == 2)  p = 12'hFFF;
    return p;
  endfunction

  task automatic send_lines(input int kind, input int first, input int lines, input bit gap);
    for (int r = first; r < first + lines; r++) begin
      for (int c = 0; c < int'(H); c++) begin
        @(negedge pclk);
        bus.we    = 1'b1;
        bus.wData = pix(kind, r, c);
        bus.wAddr = 17'(r * int'(H) + c);
        if (gap) begin
          @(negedge pclk);
          bus.we = 1'b0;
        end
      end
    end
    @(negedge pclk);
    bus.we = 1'b0;
    repeat (4) @(negedge pclk);
  endtask

  // Pulse must appear exactly one cycle after v_sync rises and last one cycle.
  task automatic vsync_pulse(input string tag, input logic exp_report);
    int n0;
    n0 = n_valid;
    @(negedge pclk);
    bus.v_sync = 1'b1;
    @(negedge pclk);
    expect_eq({tag, "_valid_s1"}, 32'(bus.focus_valid), 32'(exp_report));
    @(negedge pclk);
    expect_eq({tag, "_valid_s2"}, 32'(bus.focus_valid), 32'd0);
    repeat (4) @(negedge pclk);
    bus.v_sync = 1'b0;
    repeat (4) @(negedge pclk);
    expect_eq({tag, "_count"}, 32'(n_valid - n0), 32'(exp_report));
  endtask

  task automatic frame_check(input string tag, input int kind, input int lines, input bit gap,
                             input logic [31:0] exp_val, input logic [31:0] exp_err);
    send_lines(kind, 0, lines, gap);
    vsync_pulse(tag, 1'b1);
    expect_eq({tag, "_value"}, last_val, exp_val);
    expect_eq({tag, "_err"}, last_err, exp_err);
  endtask

  initial begin
    bus.v_sync = 1'b0;
    bus.we     = 1'b0;
    bus.wData  = '0;
    bus.wAddr  = '0;
    reset      = 1'b1;
    repeat (3) @(negedge pclk);
    expect_eq("rst_value", 32'(bus.focus_value), 32'd0);
    expect_eq("rst_valid", 32'(bus.focus_valid), 32'd0);
    expect_eq("rst_err",   32'(bus.frame_err),   32'd0);
    reset = 1'b0;

    send_lines(K_UNIFORM, 0, int'(V), 1'b1);
    vsync_pulse("first_sync", 1'b0);

    frame_check("uniform",  K_UNIFORM, int'(V), 1'b1, 32'd0,     32'd0);
    frame_check("vstripe",  K_VSTRIPE, int'(V), 1'b0, 32'd21600, 32'd0);
    frame_check("hstripe",  K_HSTRIPE, int'(V), 1'b1, 32'd21120, 32'd0);
    frame_check("dot_in",   K_DOT_IN,  int'(V), 1'b1, 32'd480,   32'd0);
    frame_check("dot_out",  K_DOT_OUT, int'(V), 1'b0, 32'd0,     32'd0);
    frame_check("short",    K_UNIFORM, 10,      1'b0, 32'd0,     32'd1);
    frame_check("after_sh", K_HSTRIPE, int'(V), 1'b0, 32'd21120, 32'd0);
    frame_check("long",     K_VSTRIPE, int'(V) + 2, 1'b0, 32'd21600, 32'd1);
    frame_check("long_dot", K_DOT_IN,  int'(V) + 1, 1'b1, 32'd480,   32'd1);

    send_lines(K_VSTRIPE, 0, 5, 1'b0);
    @(negedge pclk);
    reset = 1'b1;
    @(negedge pclk);
    expect_eq("midrst_value", 32'(bus.focus_value), 32'd0);
    expect_eq("midrst_valid", 32'(bus.focus_valid), 32'd0);
    expect_eq("midrst_err",   32'(bus.frame_err),   32'd0);
    reset = 1'b0;
    send_lines(K_VSTRIPE, 5, 8, 1'b0);
    vsync_pulse("post_rst_sync", 1'b0);
    frame_check("post_rst", K_DOT_IN, int'(V), 1'b1, 32'd480, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
